audio_tone_gen: RTL
===================

# audio_tone_gen

Hardware stereo tone source (DDS) that sits directly upstream of `i2s_master` and feeds its frame FIFO through the `frame_in_l`/`frame_in_r`/`write_frame`/`full` interface. It replaces CPU-driven sample pushing for test tones. Two independent phase accumulators index a shared quarter-wave sine table, and the result is scaled by a common amplitude. One frame is produced whenever the downstream FIFO has room.

## Interface
- `PHASE_W`, 24: phase accumulator width; tone frequency = `phase_inc` * f_frame / 2^PHASE_W.
- `LUT_AW`, 8: quarter-wave table address width (256 entries).
- `SAMPLE_W`, 24: output sample width, two's complement.
- `clk`  in  1  SoC clock (`clk_soc` domain). Single clock.
- `resetn`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  run generator; low forces IDLE and zeroes both phases.
- `phase_inc_l`, `phase_inc_r`  in  PHASE_W  per-channel phase increment.
- `amp`  in  9  unsigned gain; 256 = unity, values >256 saturate to 256.
- `frame_l`, `frame_r`  out  SAMPLE_W  samples to `i2s_master` `frame_in_l`/`frame_in_r`.
- `write_frame`  out  1  one-cycle push strobe.
- `full`  in  1  downstream FIFO full.

## Operation
- FSM states: IDLE, ADDR, LOOK, SCALE, PUSH.
- IDLE: waits for `enable`=1, then moves to ADDR.
- ADDR: captures `phase_inc_*` and `amp` into working registers, and issues table addresses for both channels from phase bits [PHASE_W-1:PHASE_W-10].
  - Top 2 bits = quadrant q; low 8 bits = index i.
  - Address = i when q is 0 or 2; 255-i when q is 1 or 3.
- LOOK: table data returns. Sign is applied: negate when q is 2 or 3. The signed result is registered.
- SCALE: sample = ((signed sample * {0, amp_sat}) >>> 8). The product is 33 bits; bits [31:8] are kept (arithmetic shift, truncates toward −∞). The result is registered into `frame_l`/`frame_r`.
- PUSH: `write_frame` = (state==PUSH && !full), combinational from `full`.
  - In the cycle it is high: both phases += their latched increments (mod 2^PHASE_W), then go to ADDR.
  - While `full`=1: hold PUSH, no strobe; phases and frame outputs are held.
- Table: LUT[k] = round(8388607·sin(π/2·(k+0.5)/256)). The half-step offset makes the four quadrants exactly symmetric, and no entry is 0.
- `enable`=0 in any state: next state IDLE, no strobe that cycle, both phases cleared to 0. Frame outputs keep their last value.
- Increment or `amp` changes mid-frame take effect at the next ADDR. A frame in flight is never mixed.

## Timing
- Reset values: all outputs 0, state IDLE, phases 0, latched increments/amp 0.
- Latency: `enable` rise → earliest `write_frame` 4 cycles later (IDLE→ADDR→LOOK→SCALE→PUSH).
- Throughput: at most one frame per 4 cycles. This is far above the audio frame rate, so the FIFO stays full in steady state and `full` is the pacing signal.
- `frame_l`/`frame_r` are stable from SCALE until the next SCALE, so they are valid in every PUSH cycle.
- `full` rising in the same cycle as a strobe: that strobe is not issued (combinational gate).
- Asynchronous reset mid-PUSH: strobe drops immediately and no frame is written.

## Structure
- Package `audio_pkg`:
  - `SAMPLE_W`, `PHASE_W`, `LUT_AW` defaults.
  - FSM state enum.
  - Table generation function (or generated `$readmemh` file `sine_quarter.mem`), shared with any future audio blocks.
- Sub-module `sine_quarter_lut`:
  - Dual read port ROM, registered outputs, 1-cycle latency.
  - Instantiated once and used for both channels.

## Test plan
- Reset: hold `resetn`=0, then release with `enable`=0 and `full`=0 → all outputs 0, no strobe over 100 cycles.
- Quadrant walk: `phase_inc_l`=2^22, `phase_inc_r`=0, `amp`=256, `full`=0.
  - L frames are 25736, 8388568, −25736, −8388568, then repeat.
  - R stays 25736.
  - Strobes are exactly 4 cycles apart.
- Gain: same stimulus with `amp`=128 → L frames are 12868, 4194284, −12868, −4194284. With `amp`=0 → all 0. With `amp`=400 → identical to `amp`=256.
- Backpressure: hold `full`=1 for 50 cycles during PUSH → no strobe and outputs frozen. Release `full` → exactly one strobe, and the next frame continues the sequence with no skipped phase.
- Enable abort and wrap:
  - Drop `enable` during LOOK → no strobe. Re-enable → first frame is again phase 0 (25736).
  - `phase_inc_l`=2^24−1 → phase decrements by 1 per frame; first frames are 25736, then −25736 (wrap into quadrant 3, index 255 → address 0, negated).
- Reset during PUSH with `full`=0 → `write_frame` falls asynchronously, and after release the sequence restarts at phase 0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio definitions: default widths, DDS sequencer states and the
// quarter-wave sine table generator used to build ROM contents at elaboration.
package audio_pkg;

    localparam int SAMPLE_W = 24;
    localparam int PHASE_W  = 24;
    localparam int LUT_AW   = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LOOK,
        SCALE,
        PUSH
    } tone_state_e;

    // Samples the centre of each step so the four quadrants mirror exactly.
    function automatic int sine_quarter_entry(input int k, input int depth, input int full_scale);
        real pi;
        real v;
        pi = 3.14159265358979323846;
        v  = real'(full_scale) * $sin(pi / 2.0 * (real'(k) + 0.5) / real'(depth));
        return $rtoi(v + 0.5);
    endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// Dual-read-port quarter-wave sine ROM with registered outputs (one cycle of latency).
module sine_quarter_lut #(
    parameter int AW = audio_pkg::LUT_AW,
    parameter int DW = audio_pkg::SAMPLE_W - 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [AW-1:0] addr_a_i,
    input  logic [AW-1:0] addr_b_i,
    output logic [DW-1:0] data_a_o,
    output logic [DW-1:0] data_b_o
);
    import audio_pkg::*;

    localparam int DEPTH      = 1 << AW;
    localparam int FULL_SCALE = (1 << DW) - 1;

    logic [DW-1:0] rom [DEPTH];
    logic [DW-1:0] data_a_q;
    logic [DW-1:0] data_b_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam int ENTRY = sine_quarter_entry(k, DEPTH, FULL_SCALE);
        assign rom[k] = ENTRY[DW-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            data_a_q <= rom[addr_a_i];
            data_b_q <= rom[addr_b_i];
        end
    end

    assign data_a_o = data_a_q;
    assign data_b_o = data_b_q;

endmodule

// File: rtl/audio_tone_gen.sv
// Stereo DDS tone source: two phase accumulators share one quarter-wave ROM,
// scale by a common gain and push one frame per free slot of the i2s frame FIFO.
module audio_tone_gen #(
    parameter int PHASE_W  = audio_pkg::PHASE_W,
    parameter int LUT_AW   = audio_pkg::LUT_AW,
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic [PHASE_W-1:0]  phase_inc_l,
    input  logic [PHASE_W-1:0]  phase_inc_r,
    input  logic [8:0]          amp,
    output logic [SAMPLE_W-1:0] frame_l,
    output logic [SAMPLE_W-1:0] frame_r,
    output logic                write_frame,
    input  logic                full
);
    import audio_pkg::*;

    localparam int QW     = LUT_AW + 2;
    localparam int PROD_W = SAMPLE_W + 10;

    tone_state_e                state_q,   state_d;
    logic [PHASE_W-1:0]         phase_l_q, phase_l_d, phase_r_q, phase_r_d;
    logic [PHASE_W-1:0]         inc_l_q,   inc_l_d,   inc_r_q,   inc_r_d;
    logic [8:0]                 amp_q,     amp_d;
    logic [1:0]                 quad_l_q,  quad_l_d,  quad_r_q,  quad_r_d;
    logic signed [SAMPLE_W-1:0] samp_l_q,  samp_l_d,  samp_r_q,  samp_r_d;
    logic [SAMPLE_W-1:0]        frame_l_q, frame_l_d, frame_r_q, frame_r_d;

    logic [1:0]                 quad_l, quad_r;
    logic [LUT_AW-1:0]          idx_l, idx_r, addr_l, addr_r;
    logic [SAMPLE_W-2:0]        lut_l, lut_r;
    logic signed [PROD_W-1:0]   prod_l, prod_r;

    // Odd quadrants read the table backwards; ~i is 255-i for an 8-bit index.
    assign {quad_l, idx_l} = phase_l_q[PHASE_W-1 -: QW];
    assign {quad_r, idx_r} = phase_r_q[PHASE_W-1 -: QW];
    assign addr_l = quad_l[0] ? ~idx_l : idx_l;
    assign addr_r = quad_r[0] ? ~idx_r : idx_r;

    sine_quarter_lut #(
        .AW(LUT_AW),
        .DW(SAMPLE_W - 1)
    ) u_lut (
        .clk     (clk),
        .resetn  (resetn),
        .addr_a_i(addr_l),
        .addr_b_i(addr_r),
        .data_a_o(lut_l),
        .data_b_o(lut_r)
    );

    assign prod_l = PROD_W'(samp_l_q) * PROD_W'($signed({1'b0, amp_q}));
    assign prod_r = PROD_W'(samp_r_q) * PROD_W'($signed({1'b0, amp_q}));

    always_comb begin
        state_d     = state_q;
        phase_l_d   = phase_l_q;
        phase_r_d   = phase_r_q;
        inc_l_d     = inc_l_q;
        inc_r_d     = inc_r_q;
        amp_d       = amp_q;
        quad_l_d    = quad_l_q;
        quad_r_d    = quad_r_q;
        samp_l_d    = samp_l_q;
        samp_r_d    = samp_r_q;
        frame_l_d   = frame_l_q;
        frame_r_d   = frame_r_q;
        write_frame = 1'b0;
        if (!enable) begin
            state_d   = IDLE;
            phase_l_d = '0;
            phase_r_d = '0;
        end else begin
            case (state_q)
                IDLE: state_d = ADDR;
                ADDR: begin
                    state_d  = LOOK;
                    inc_l_d  = phase_inc_l;
                    inc_r_d  = phase_inc_r;
                    amp_d    = (amp > 9'd256) ? 9'd256 : amp;
                    quad_l_d = quad_l;
                    quad_r_d = quad_r;
                end
                LOOK: begin
                    state_d  = SCALE;
                    samp_l_d = quad_l_q[1] ? -$signed({1'b0, lut_l}) : $signed({1'b0, lut_l});
                    samp_r_d = quad_r_q[1] ? -$signed({1'b0, lut_r}) : $signed({1'b0, lut_r});
                end
                SCALE: begin
                    state_d   = PUSH;
                    frame_l_d = SAMPLE_W'(prod_l >>> 8);
                    frame_r_d = SAMPLE_W'(prod_r >>> 8);
                end
                PUSH: begin
                    if (!full) begin
                        write_frame = 1'b1;
                        phase_l_d   = phase_l_q + inc_l_q;
                        phase_r_d   = phase_r_q + inc_r_q;
                        state_d     = ADDR;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            phase_l_q <= '0;
            phase_r_q <= '0;
            inc_l_q   <= '0;
            inc_r_q   <= '0;
            amp_q     <= '0;
            quad_l_q  <= '0;
            quad_r_q  <= '0;
            samp_l_q  <= '0;
            samp_r_q  <= '0;
            frame_l_q <= '0;
            frame_r_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_l_q <= phase_l_d;
            phase_r_q <= phase_r_d;
            inc_l_q   <= inc_l_d;
            inc_r_q   <= inc_r_d;
            amp_q     <= amp_d;
            quad_l_q  <= quad_l_d;
            quad_r_q  <= quad_r_d;
            samp_l_q  <= samp_l_d;
            samp_r_q  <= samp_r_d;
            frame_l_q <= frame_l_d;
            frame_r_q <= frame_r_d;
        end
    end

    assign frame_l = frame_l_q;
    assign frame_r = frame_r_q;

endmodule
